// File: rtl/fetch_stage.sv
// Instruction fetch: drives pc into the 64-word memory and captures the returned word into ir.
// Latency: 1 cycle from pc to ir; redirect costs a one-cycle bubble; first capture two posedges after reset release.
// Backpressure: stall holds pc/ir/ir_pc/ir_valid/fetch_count; a redirect overrides stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_BYTES   = 256,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] inst_in,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic        halted,
    output logic        fault,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    // Redirect targets are forced to word alignment; the low bits are dropped.
    logic [31:0] target_aligned;
    logic [32:0] pc_plus4;
    logic        target_out_of_range;
    logic        next_out_of_range;
    logic        is_halt_word;
    logic        unused_target_lsbs;

    assign target_aligned      = {redirect_target[31:2], 2'b00};
    assign unused_target_lsbs  = ^redirect_target[1:0];
    // 33-bit sum so a pc near 2^32 cannot wrap back into range.
    assign pc_plus4            = {1'b0, pc_q} + 33'd4;
    assign target_out_of_range = {1'b0, target_aligned} >= MEM_LIMIT;
    assign next_out_of_range   = pc_plus4 >= MEM_LIMIT;
    assign is_halt_word        = inst_in[31:26] == HALT_OPCODE;

    // Next-state and datapath: redirect beats stall, stall beats capture.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            // Memory contents are not trusted yet; spend one cycle without capturing.
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    // Drop the in-flight word; pc still takes an out-of-range target so it is visible.
                    ir_valid_d = 1'b0;
                    pc_d       = target_aligned;
                    if (target_out_of_range) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                end else if (!stall) begin
                    ir_d       = inst_in;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (fetch_count_q != 16'hFFFF) begin
                        fetch_count_d = fetch_count_q + 16'd1;
                    end
                    if (is_halt_word) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (next_out_of_range) begin
                        // The last in-range word is still delivered alongside the fault.
                        pc_d    = pc_plus4[31:0];
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = pc_plus4[31:0];
                    end
                end
            end

            // Terminal states: pc frozen, redirects ignored, last word retired once downstream accepts it.
            ST_HALT, ST_FAULT: begin
                if (!stall) begin
                    ir_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with asynchronous reset to the boot values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            ir_q          <= 32'd0;
            ir_pc_q       <= 32'd0;
            ir_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational 64-word memory model.
// Outputs sampled 1 time unit after each posedge; inputs driven right after sampling.
// Stall and redirect are driven directly from the stimulus sequence.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst_in;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];
    int          n_checks;
    int          n_fail;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .MEM_BYTES   (256),
        .HALT_OPCODE (6'h3F)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .inst_in         (inst_in),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .halted          (halted),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, zero outside the array.
    always_comb begin
        inst_in = 32'd0;
        if (pc < 32'd256) inst_in = mem[pc[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between clock edges; rst falls 6 units after a posedge.
    task automatic apply_reset();
        @(posedge clk);
        #4;
        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0400_0000 | 32'(i);
        mem[0]  = 32'h0100_0000;
        mem[1]  = 32'h0200_0000;
        mem[2]  = 32'h0300_0000;
        mem[3]  = 32'hFC00_0000;
        mem[8]  = 32'h0800_0008;
        mem[63] = 32'h0BAD_BEEF;

        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_count", 32'(fetch_count), 32'h0);
        #1;
        rst = 1'b0;

        // Sequential fetch up to HALT.
        step();
        chk("boot_no_capture", 32'(ir_valid), 32'h0);
        chk("boot_pc", pc, 32'h0);
        step();
        chk("seq_ir0", ir, 32'h0100_0000);
        chk("seq_ir_pc0", ir_pc, 32'h0);
        chk("seq_valid0", 32'(ir_valid), 32'h1);
        step();
        chk("seq_ir1", ir, 32'h0200_0000);
        chk("seq_ir_pc1", ir_pc, 32'h4);
        step();
        chk("seq_ir2", ir, 32'h0300_0000);
        chk("seq_ir_pc2", ir_pc, 32'h8);
        chk("seq_halted_early", 32'(halted), 32'h0);
        step();
        chk("seq_ir3", ir, 32'hFC00_0000);
        chk("seq_ir_pc3", ir_pc, 32'hC);
        chk("seq_halted", 32'(halted), 32'h1);
        chk("seq_count", 32'(fetch_count), 32'h4);
        chk("seq_halt_pc", pc, 32'hC);
        step();
        chk("halt_valid_drop", 32'(ir_valid), 32'h0);
        chk("halt_pc_frozen", pc, 32'hC);
        redirect_valid  = 1'b1;
        redirect_target = 32'h10;
        step();
        chk("halt_redirect_ignored", pc, 32'hC);
        redirect_valid = 1'b0;

        // Stall with ir=word1 and pc=8.
        apply_reset();
        step();
        step();
        step();
        chk("stall_pre_ir", ir, 32'h0200_0000);
        chk("stall_pre_pc", pc, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ir", ir, 32'h0200_0000);
            chk("stall_pc", pc, 32'h8);
            chk("stall_count", 32'(fetch_count), 32'h2);
            chk("stall_valid", 32'(ir_valid), 32'h1);
        end
        stall = 1'b0;
        step();
        chk("stall_next_ir", ir, 32'h0300_0000);
        chk("stall_next_ir_pc", ir_pc, 32'h8);
        chk("stall_next_count", 32'(fetch_count), 32'h3);

        // Unaligned redirect together with stall.
        apply_reset();
        step();
        step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h23;
        stall           = 1'b1;
        step();
        chk("redir_pc", pc, 32'h20);
        chk("redir_bubble", 32'(ir_valid), 32'h0);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();
        chk("redir_ir", ir, 32'h0800_0008);
        chk("redir_ir_pc", ir_pc, 32'h20);
        chk("redir_valid", 32'(ir_valid), 32'h1);
        chk("redir_count", 32'(fetch_count), 32'h2);

        // Out-of-range redirect.
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        chk("oor_fault", 32'(fault), 32'h1);
        chk("oor_pc", pc, 32'h100);
        chk("oor_valid", 32'(ir_valid), 32'h0);
        redirect_target = 32'h10;
        step();
        chk("oor_redirect_ignored", pc, 32'h100);
        chk("oor_fault_sticky", 32'(fault), 32'h1);
        chk("oor_not_halted", 32'(halted), 32'h0);
        redirect_valid = 1'b0;

        // Sequential fetch off the end of memory.
        apply_reset();
        step();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFC;
        step();
        chk("end_pc_fc", pc, 32'hFC);
        chk("end_no_fault_yet", 32'(fault), 32'h0);
        redirect_valid = 1'b0;
        stall          = 1'b1;
        step();
        chk("end_stall_pc", pc, 32'hFC);
        stall = 1'b0;
        step();
        chk("end_ir", ir, 32'h0BAD_BEEF);
        chk("end_ir_pc", ir_pc, 32'hFC);
        chk("end_valid", 32'(ir_valid), 32'h1);
        chk("end_fault", 32'(fault), 32'h1);
        chk("end_pc", pc, 32'h100);
        stall = 1'b1;
        step();
        chk("end_stall_hold_valid", 32'(ir_valid), 32'h1);
        stall = 1'b0;
        step();
        chk("end_valid_drop", 32'(ir_valid), 32'h0);
        chk("end_pc_frozen", pc, 32'h100);

        // Asynchronous reset mid-run with pc=0x40, ir_valid=1.
        apply_reset();
        step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h3C;
        step();
        redirect_valid = 1'b0;
        step();
        chk("ar_pre_pc", pc, 32'h40);
        chk("ar_pre_valid", 32'(ir_valid), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_pc", pc, 32'h0);
        chk("ar_ir", ir, 32'h0);
        chk("ar_ir_pc", ir_pc, 32'h0);
        chk("ar_valid", 32'(ir_valid), 32'h0);
        chk("ar_count", 32'(fetch_count), 32'h0);
        chk("ar_fault", 32'(fault), 32'h0);
        #1;
        rst = 1'b0;
        step();
        chk("ar_boot_no_capture", 32'(ir_valid), 32'h0);
        step();
        chk("ar_first_ir", ir, 32'h0100_0000);
        chk("ar_first_valid", 32'(ir_valid), 32'h1);
        chk("ar_first_ir_pc", ir_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
